btn_press_classifier: RTL and testbench
=======================================

BTN_PRESS_CLASSIFIER -- requirements
Module: btn_press_classifier

Interface
REQ-001 SHALL have parameter TICK_DIV, default 500000: clk cycles per timing tick (10 ms at 50 MHz); legal range >= 2.
REQ-002 SHALL have parameter LONG_TICKS, default 100: ticks a press must be held to count as long; legal range >= 2.
REQ-003 SHALL have parameter REPEAT_TICKS, default 20: ticks between auto-repeat pulses while a long press is held; legal range >= 1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge triggered.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port db, input, 1 bit: debounced button level from the upstream debouncer, already synchronous to clk.
REQ-007 SHALL have port press_pulse, output, 1 bit: one-cycle pulse on each accepted press.
REQ-008 SHALL have port short_pulse, output, 1 bit: one-cycle pulse on release before the long threshold.
REQ-009 SHALL have port long_pulse, output, 1 bit: one-cycle pulse when the long threshold is reached while still held.
REQ-010 SHALL have port rep_pulse, output, 1 bit: one-cycle auto-repeat pulse during a long hold.
REQ-011 SHALL have port release_pulse, output, 1 bit: one-cycle pulse on any release that ends a tracked press.
REQ-012 SHALL have port held, output, 1 bit: high while the FSM is in PRESS or LONG.

Function
REQ-013 SHALL register db into db_q each cycle; a rise is db=1 with db_q=0, and a fall is db=0 with db_q=1.
REQ-014 SHALL drive all outputs from registers, so each pulse asserts the cycle after its causing event and lasts exactly 1 cycle.
REQ-015 SHALL implement an FSM with states IDLE, PRESS and LONG.
REQ-016 SHALL, in IDLE on a rise: go to PRESS, clear the tick prescaler and hold counter, and assert press_pulse.
REQ-017 SHALL generate the tick when the prescaler equals TICK_DIV-1, then wrap the prescaler to 0; the prescaler runs freely otherwise.
REQ-018 SHALL, in PRESS, increment the hold counter on each tick; when a tick makes the count equal LONG_TICKS while db=1: go to LONG, clear the repeat counter, and assert long_pulse.
REQ-019 SHALL time long_pulse to assert exactly LONG_TICKS*TICK_DIV cycles after press_pulse.
REQ-020 SHALL, in PRESS on a fall: go to IDLE and assert short_pulse and release_pulse in the same cycle.
REQ-021 SHALL, in LONG, increment the repeat counter on each tick; on reaching REPEAT_TICKS it asserts rep_pulse and clears to 0, so rep_pulse occurs every REPEAT_TICKS*TICK_DIV cycles after long_pulse.
REQ-022 SHALL, in LONG on a fall: go to IDLE and assert release_pulse only (no short_pulse, no rep_pulse that cycle).
REQ-023 SHALL give a fall priority when it coincides with a threshold tick: in PRESS this yields short_pulse and no long_pulse; in LONG this yields no rep_pulse.
REQ-024 SHALL size the counters as $clog2 of their limit + 1; the counters cannot overflow because they are cleared at their thresholds.
REQ-025 SHALL map unreachable state encodings to IDLE on the next cycle, with all pulses low.

Reset
REQ-026 SHALL, while reset=1: set state to IDLE, clear all counters, drive every output 0, and load db_q with 1.
REQ-027 SHALL, because db_q resets to 1, ignore a button held through reset release until it is released and pressed again.
REQ-028 SHALL abort a press when reset occurs mid-press, emitting no short, long or release pulse.

Structure
REQ-029 SHALL place the state enum (IDLE/PRESS/LONG) and default parameter values in shared package btn_pkg.
REQ-030 SHALL use one sub-module, tick_gen: a parameterised prescaler with a sync clear input and a one-cycle tick output.

Verification (TICK_DIV=4, LONG_TICKS=5, REPEAT_TICKS=2)
REQ-031 SHALL cover: db 0->1 at cycle 10, released at cycle 20 -> press_pulse at 11; short_pulse and release_pulse at 21; no long_pulse.
REQ-032 SHALL cover: db rises at cycle 10 and is held -> press_pulse at 11, long_pulse at 31, rep_pulse at 39, 47 and 55; held=1 throughout.
REQ-033 SHALL cover: a long hold released at cycle 50 -> release_pulse at 51 only; no short_pulse; no further rep_pulse.
REQ-034 SHALL cover: db falls on the exact cycle of the 5th tick -> short_pulse and no long_pulse.
REQ-035 SHALL cover: db=1 across reset release -> no press_pulse; after db 0 then 1, press_pulse follows 1 cycle after the rise.
REQ-036 SHALL cover: reset asserted at cycle 25 during PRESS -> all outputs 0 from cycle 26; no pulses emitted for the aborted press.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and default timing parameters for the button press classifier.
package btn_pkg;

  localparam int unsigned DEF_TICK_DIV     = 500000;
  localparam int unsigned DEF_LONG_TICKS   = 100;
  localparam int unsigned DEF_REPEAT_TICKS = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_LONG  = 2'd2
  } btn_state_e;

  // One bit per event pulse, registered together.
  typedef struct packed {
    logic press_p;
    logic short_p;
    logic long_p;
    logic rep_p;
    logic release_p;
  } btn_pulses_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-cycle tick every DIV clocks, with sync clear.
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick_c
);

  localparam int unsigned CNT_W = $clog2(DIV + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick_c = (cnt == LAST);

endmodule

// File: rtl/btn_press_classifier.sv
// Classifies a debounced button into press / short / long / repeat / release pulses.
module btn_press_classifier
  import btn_pkg::*;
#(
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS,
  parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic db,
  output logic press_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic rep_pulse,
  output logic release_pulse,
  output logic held
);

  localparam int unsigned HOLD_W = $clog2(LONG_TICKS + 1);
  localparam int unsigned REP_W  = $clog2(REPEAT_TICKS + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_TICKS - 1);

  btn_state_e        state;
  btn_state_e        state_next;
  logic              db_q;
  logic              rise_c;
  logic              fall_c;
  logic              tick_c;
  logic              presc_clear_c;
  logic              hold_done_c;
  logic              rep_done_c;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_cnt_next;
  logic [REP_W-1:0]  rep_cnt;
  logic [REP_W-1:0]  rep_cnt_next;
  btn_pulses_t       pulses_q;
  btn_pulses_t       pulses_next;
  logic              held_q;
  logic              held_next;

  assign rise_c      = db & ~db_q;
  assign fall_c      = ~db & db_q;
  assign hold_done_c = tick_c && (hold_cnt == HOLD_LAST);
  assign rep_done_c  = tick_c && (rep_cnt == REP_LAST);

  tick_gen #(
    .DIV(TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clear (presc_clear_c),
    .tick_c(tick_c)
  );

  // State, edge-detect and counter registers; db_q resets high so a held button is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      db_q     <= 1'b1;
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else begin
      state    <= state_next;
      db_q     <= db;
      hold_cnt <= hold_cnt_next;
      rep_cnt  <= rep_cnt_next;
    end
  end

  // Next state and counter updates; a fall always wins over a coincident tick.
  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    rep_cnt_next  = rep_cnt;
    presc_clear_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise_c) begin
          state_next    = ST_PRESS;
          hold_cnt_next = '0;
          presc_clear_c = 1'b1;
        end
      end
      ST_PRESS: begin
        if (fall_c) begin
          state_next = ST_IDLE;
        end else if (tick_c) begin
          if (hold_done_c) begin
            state_next    = ST_LONG;
            hold_cnt_next = '0;
            rep_cnt_next  = '0;
          end else begin
            hold_cnt_next = hold_cnt + HOLD_W'(1);
          end
        end
      end
      ST_LONG: begin
        if (fall_c) begin
          state_next = ST_IDLE;
        end else if (tick_c) begin
          rep_cnt_next = rep_done_c ? '0 : rep_cnt + REP_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    pulses_next = '0;
    held_next   = 1'b0;
    case (state)
      ST_IDLE: begin
        pulses_next.press_p = rise_c;
        held_next           = rise_c;
      end
      ST_PRESS: begin
        if (fall_c) begin
          pulses_next.short_p   = 1'b1;
          pulses_next.release_p = 1'b1;
        end else begin
          pulses_next.long_p = hold_done_c;
          held_next          = 1'b1;
        end
      end
      ST_LONG: begin
        if (fall_c) begin
          pulses_next.release_p = 1'b1;
        end else begin
          pulses_next.rep_p = rep_done_c;
          held_next         = 1'b1;
        end
      end
      default: begin
        pulses_next = '0;
        held_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pulses_q <= '0;
      held_q   <= 1'b0;
    end else begin
      pulses_q <= pulses_next;
      held_q   <= held_next;
    end
  end

  assign press_pulse   = pulses_q.press_p;
  assign short_pulse   = pulses_q.short_p;
  assign long_pulse    = pulses_q.long_p;
  assign rep_pulse     = pulses_q.rep_p;
  assign release_pulse = pulses_q.release_p;
  assign held          = held_q;

endmodule

// File: tb/tb_btn_press_classifier.sv
// Bench for btn_press_classifier: directed scenarios with point checks plus random traces vs an event model.
module tb_btn_press_classifier;

  localparam int TICK_DIV     = 4;
  localparam int LONG_TICKS   = 5;
  localparam int REPEAT_TICKS = 2;
  localparam int MAXC         = 1024;
  localparam int LONG_AGE     = LONG_TICKS * TICK_DIV;
  localparam int REP_PERIOD   = REPEAT_TICKS * TICK_DIV;

  logic clk;
  logic reset;
  logic db;
  logic press_pulse, short_pulse, long_pulse, rep_pulse, release_pulse, held;
  logic [5:0] outs;

  // Output vector order: {press, short, long, rep, release, held}
  assign outs = {press_pulse, short_pulse, long_pulse, rep_pulse, release_pulse, held};

  btn_press_classifier #(
    .TICK_DIV    (TICK_DIV),
    .LONG_TICKS  (LONG_TICKS),
    .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .db           (db),
    .press_pulse  (press_pulse),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .rep_pulse    (rep_pulse),
    .release_pulse(release_pulse),
    .held         (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int n;
    int rise;
    int fall;
    int rst_lo;
    int rst_hi;
    bit pre_high;
  } scen_t;

  typedef struct {
    string      name;
    int         scen;
    int         cyc;
    logic [5:0] exp;
  } vec_t;

  logic       db_tr  [MAXC];
  logic       rst_tr [MAXC];
  logic [5:0] out_tr [MAXC+1];
  logic [5:0] exp_tr [MAXC+1];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int cyc, input logic [5:0] got,
                       input logic [5:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%b expected=%b (press,short,long,rep,release,held)",
               name, cyc, got, exp);
    end
  endtask

  task automatic clear_trace();
    for (int c = 0; c < MAXC; c++) begin
      db_tr[c]  = 1'b0;
      rst_tr[c] = 1'b0;
    end
  endtask

  // Reset preamble with db at its first traced level, then cycle c drives inputs before edge c.
  task automatic run_trace(input int n);
    @(negedge clk);
    reset = 1'b1;
    db    = db_tr[0];
    repeat (3) @(posedge clk);
    @(negedge clk);
    out_tr[0] = outs;
    for (int c = 0; c < n; c++) begin
      db    = db_tr[c];
      reset = rst_tr[c];
      @(posedge clk);
      @(negedge clk);
      out_tr[c+1] = outs;
    end
  endtask

  // Event model: outputs derived from the age of the accepted press in clock cycles.
  function automatic void build_model(input int n);
    int   press_at;
    int   age;
    logic db_prev;
    logic p, s, l, r, rl, h;
    press_at  = -1;
    db_prev   = 1'b1;
    exp_tr[0] = '0;
    for (int c = 0; c < n; c++) begin
      {p, s, l, r, rl, h} = 6'b0;
      if (rst_tr[c]) begin
        press_at = -1;
        db_prev  = 1'b1;
      end else begin
        if (press_at < 0) begin
          if (db_tr[c] && !db_prev) begin
            press_at = c;
            p = 1'b1;
            h = 1'b1;
          end
        end else begin
          age = c - press_at;
          if (!db_tr[c]) begin
            rl       = 1'b1;
            s        = (age <= LONG_AGE);
            press_at = -1;
          end else begin
            h = 1'b1;
            l = (age == LONG_AGE);
            r = (age > LONG_AGE) && ((age - LONG_AGE) % REP_PERIOD == 0);
          end
        end
        db_prev = db_tr[c];
      end
      exp_tr[c+1] = {p, s, l, r, rl, h};
    end
  endfunction

  task automatic build_scen(input scen_t sc);
    clear_trace();
    for (int c = 0; c < sc.n; c++) begin
      if (c < 10 && sc.pre_high) db_tr[c] = 1'b1;
      else if (c >= sc.rise && (sc.fall < 0 || c < sc.fall)) db_tr[c] = 1'b1;
      if (c >= sc.rst_lo && c <= sc.rst_hi) rst_tr[c] = 1'b1;
    end
  endtask

  // Random high/low runs biased to hit the long threshold exactly, plus occasional resets.
  task automatic build_random(input int n);
    int   c;
    int   len;
    int   kind;
    logic lvl;
    clear_trace();
    c   = 0;
    lvl = 1'($urandom_range(0, 1));
    while (c < n) begin
      if (lvl) begin
        kind = $urandom_range(0, 3);
        case (kind)
          0:       len = $urandom_range(1, LONG_AGE - 1);
          1:       len = LONG_AGE;
          2:       len = LONG_AGE + 1;
          default: len = $urandom_range(LONG_AGE + 2, 80);
        endcase
      end else begin
        len = $urandom_range(1, 8);
      end
      for (int k = 0; k < len && c < n; k++) begin
        db_tr[c] = lvl;
        c++;
      end
      lvl = ~lvl;
    end
    repeat ($urandom_range(0, 2)) begin
      c = $urandom_range(1, n - 3);
      rst_tr[c] = 1'b1;
      if ($urandom_range(0, 1) == 1) rst_tr[c+1] = 1'b1;
    end
  endtask

  task automatic compare_all(input string name, input int n);
    for (int c = 0; c <= n; c++) check(name, c, out_tr[c], exp_tr[c]);
  endtask

  scen_t scens [6];
  vec_t  vecs  [$];

  initial begin
    reset = 1'b1;
    db    = 1'b0;

    scens[0] = '{40, 10, 20, -1, -1, 1'b0};
    scens[1] = '{60, 10, -1, -1, -1, 1'b0};
    scens[2] = '{70, 10, 50, -1, -1, 1'b0};
    scens[3] = '{40, 10, 30, -1, -1, 1'b0};
    scens[4] = '{30, 15, -1, -1, -1, 1'b1};
    scens[5] = '{45, 10, 30, 25, 26, 1'b0};

    vecs.push_back('{"reset_state",    0,  0, 6'b000000});
    vecs.push_back('{"short_press",    0, 11, 6'b100001});
    vecs.push_back('{"short_held",     0, 12, 6'b000001});
    vecs.push_back('{"short_held_end", 0, 20, 6'b000001});
    vecs.push_back('{"short_release",  0, 21, 6'b010010});
    vecs.push_back('{"short_after",    0, 22, 6'b000000});
    vecs.push_back('{"short_no_long",  0, 31, 6'b000000});
    vecs.push_back('{"long_press",     1, 11, 6'b100001});
    vecs.push_back('{"long_before",    1, 30, 6'b000001});
    vecs.push_back('{"long_pulse",     1, 31, 6'b001001});
    vecs.push_back('{"long_after",     1, 32, 6'b000001});
    vecs.push_back('{"rep_1",          1, 39, 6'b000101});
    vecs.push_back('{"rep_2",          1, 47, 6'b000101});
    vecs.push_back('{"rep_3",          1, 55, 6'b000101});
    vecs.push_back('{"rep_gap",        1, 56, 6'b000001});
    vecs.push_back('{"long_rel_before",2, 49, 6'b000001});
    vecs.push_back('{"long_release",   2, 51, 6'b000010});
    vecs.push_back('{"long_rel_after", 2, 52, 6'b000000});
    vecs.push_back('{"long_no_rep",    2, 55, 6'b000000});
    vecs.push_back('{"edge_held",      3, 30, 6'b000001});
    vecs.push_back('{"edge_fall_tick", 3, 31, 6'b010010});
    vecs.push_back('{"edge_after",     3, 32, 6'b000000});
    vecs.push_back('{"held_thru_rst",  4,  1, 6'b000000});
    vecs.push_back('{"held_thru_rst2", 4, 10, 6'b000000});
    vecs.push_back('{"untracked_rel",  4, 11, 6'b000000});
    vecs.push_back('{"repress_quiet",  4, 15, 6'b000000});
    vecs.push_back('{"repress_pulse",  4, 16, 6'b100001});
    vecs.push_back('{"abort_held",     5, 25, 6'b000001});
    vecs.push_back('{"abort_reset",    5, 26, 6'b000000});
    vecs.push_back('{"abort_reset2",   5, 27, 6'b000000});
    vecs.push_back('{"abort_no_rel",   5, 31, 6'b000000});
    vecs.push_back('{"abort_no_long",  5, 32, 6'b000000});

    for (int s = 0; s < 6; s++) begin
      build_scen(scens[s]);
      run_trace(scens[s].n);
      build_model(scens[s].n);
      compare_all($sformatf("scen%0d_model", s), scens[s].n);
      foreach (vecs[i]) begin
        if (vecs[i].scen == s) check(vecs[i].name, vecs[i].cyc, out_tr[vecs[i].cyc], vecs[i].exp);
      end
    end

    for (int t = 0; t < 10; t++) begin
      build_random(500);
      run_trace(500);
      build_model(500);
      compare_all($sformatf("random%0d", t), 500);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
